// File: rtl/read_to_sdram_pkg.sv
// Shared types for the FX2 FIFO to SDRAM bridge.
// State encodings and Wishbone/FX2 tie-off constants.
package read_to_sdram_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WB    = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] FIFOADR_EP2 = 2'b00;
  localparam logic [3:0] WB_SEL_ALL  = 4'hF;

endpackage

// File: rtl/read_to_sdram.sv
// Drains 16-bit FX2 slave-FIFO words, packs pairs into 32-bit words and
// writes NUM_WORDS of them to SDRAM over a Wishbone master port.
// Ports: CLKOUT/rst_n clock+reset; IFCLK,FLAGA,FDATA,SLRD,SLOE,SLWR,FIFOADR
// FX2 pins; cyc_i..data_i Wishbone master; cstate,LED,read_ack debug.
module read_to_sdram
  import read_to_sdram_pkg::*;
#(
  parameter int          NUM_WORDS = 120,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  output logic        IFCLK,
  input  logic        FLAGA,
  inout  wire  [15:0] FDATA,
  output logic        SLRD,
  output logic        SLOE,
  output logic        SLWR,
  output logic [1:0]  FIFOADR,
  output logic [3:0]  LED,
  output logic [2:0]  cstate,
  output logic        read_ack,
  input  logic [31:0] data_o,
  input  logic        stall_o,
  input  logic        sdram_ack,
  output logic        cyc_i,
  output logic        stb_i,
  output logic        we_i,
  output logic [3:0]  sel_i,
  output logic [31:0] addr_i,
  output logic [31:0] data_i
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS);

  state_t          state, state_n;
  logic [31:0]     word;
  logic [31:0]     addr;
  logic [CW-1:0]   count;
  logic            rd_st;
  logic            take;
  logic            wb_done;
  logic            unused_rdata;

  assign unused_rdata = ^data_o;

  assign FDATA = 16'hzzzz;

  // A FIFO word is only popped in a cycle where FLAGA says one exists,
  // so a flag drop between halves simply stalls the read state.
  assign rd_st   = (state == S_RD_LO) || (state == S_RD_HI);
  assign take    = rd_st && FLAGA;
  assign wb_done = (state == S_WB) && sdram_ack && !stall_o;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (FLAGA) state_n = S_RD_LO;
      S_RD_LO: if (FLAGA) state_n = S_RD_HI;
      S_RD_HI: if (FLAGA) state_n = S_WB;
      S_WB:    if (wb_done) state_n = S_GAP;
      S_GAP:   state_n = (count == LAST) ? S_DONE : S_IDLE;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      word  <= '0;
      addr  <= BASE_ADDR;
      count <= '0;
    end else begin
      state <= state_n;
      if (take && state == S_RD_LO) word[15:0]  <= FDATA;
      if (take && state == S_RD_HI) word[31:16] <= FDATA;
      if (wb_done) begin
        addr  <= addr + 32'd1;
        count <= count + CW'(1);
      end
    end
  end

  assign IFCLK    = CLKOUT;
  assign SLRD     = !take;
  assign SLOE     = !rd_st;
  assign SLWR     = 1'b1;
  assign FIFOADR  = FIFOADR_EP2;
  assign cyc_i    = (state == S_WB);
  assign stb_i    = (state == S_WB);
  assign we_i     = (state == S_WB);
  assign sel_i    = WB_SEL_ALL;
  assign addr_i   = addr;
  assign data_i   = word;
  assign cstate   = state;
  assign read_ack = (state == S_DONE);
  assign LED      = {read_ack, cstate};

endmodule

// File: tb/tb_read_to_sdram.sv
// Directed bench for read_to_sdram: FX2 FIFO source, Wishbone slave
// with 4-cycle held ack, write log, stall/flag-gap/reset scenarios.
module tb_read_to_sdram;

  logic        CLKOUT = 1'b0;
  logic        rst_n;
  logic        IFCLK;
  logic        FLAGA;
  wire  [15:0] FDATA;
  logic        SLRD, SLOE, SLWR;
  logic [1:0]  FIFOADR;
  logic [3:0]  LED;
  logic [2:0]  cstate;
  logic        read_ack;
  logic [31:0] data_o;
  logic        stall_o;
  logic        sdram_ack;
  logic        cyc_i, stb_i, we_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i, data_i;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] fcnt;
  logic [2:0]  ack_cnt;
  logic        prev_acc;
  int          b2b = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  logic [31:0] a0, d0;
  int          k;

  always #5 CLKOUT = ~CLKOUT;

  assign FDATA = fcnt;

  read_to_sdram dut (
    .CLKOUT(CLKOUT), .rst_n(rst_n), .IFCLK(IFCLK), .FLAGA(FLAGA),
    .FDATA(FDATA), .SLRD(SLRD), .SLOE(SLOE), .SLWR(SLWR),
    .FIFOADR(FIFOADR), .LED(LED), .cstate(cstate),
    .read_ack(read_ack), .data_o(data_o), .stall_o(stall_o),
    .sdram_ack(sdram_ack), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .addr_i(addr_i), .data_i(data_i)
  );

  // FIFO source: one new value per edge where the strobe is low
  always @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) fcnt <= 16'd0;
    else if (!SLRD) fcnt <= fcnt + 16'd1;
  end

  // Wishbone slave: ack 4 cycles into a cycle, held until cyc drops
  always @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt   <= 3'd0;
      sdram_ack <= 1'b0;
      prev_acc  <= 1'b0;
      wr_addr.delete();
      wr_data.delete();
    end else begin
      if (prev_acc && cyc_i) b2b <= b2b + 1;
      prev_acc <= cyc_i && stb_i && sdram_ack && !stall_o;
      if (cyc_i && stb_i && sdram_ack && !stall_o) begin
        wr_addr.push_back(addr_i);
        wr_data.push_back(data_i);
      end
      if (cyc_i && stb_i) begin
        if (ack_cnt == 3'd3) sdram_ack <= 1'b1;
        else ack_cnt <= ack_cnt + 3'd1;
      end else begin
        ack_cnt   <= 3'd0;
        sdram_ack <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim,
                            input string tag);
    int n = 0;
    while (cstate !== s && n < lim) begin
      @(negedge CLKOUT);
      n++;
    end
    chk(tag, {29'd0, cstate}, {29'd0, s});
  endtask

  task automatic wait_writes(input int target, input int lim,
                             input string tag);
    int n = 0;
    while (wr_addr.size() < target && n < lim) begin
      @(negedge CLKOUT);
      n++;
    end
    chk(tag, wr_addr.size(), target);
  endtask

  initial begin
    rst_n   = 1'b0;
    FLAGA   = 1'b0;
    stall_o = 1'b0;
    data_o  = 32'hDEAD_BEEF;
    #2 rst_n = 1'b1;

    @(negedge CLKOUT);
    chk("rst_state", {29'd0, cstate}, 32'd0);
    chk("rst_slrd", {31'd0, SLRD}, 32'd1);
    chk("rst_sloe", {31'd0, SLOE}, 32'd1);
    chk("rst_cyc", {31'd0, cyc_i}, 32'd0);
    chk("rst_addr", addr_i, 32'd0);
    chk("rst_data", data_i, 32'd0);
    chk("rst_led", {28'd0, LED}, 32'd0);
    chk("tieoffs", {25'd0, SLWR, FIFOADR, sel_i}, {25'd0, 1'b1, 2'b00, 4'hF});

    repeat (2) @(negedge CLKOUT);
    chk("idle_empty", {28'd0, cstate, SLRD}, {28'd0, 3'd0, 1'b1});
    FLAGA = 1'b1;

    wait_writes(1, 40, "first_write");
    chk("w0_addr", wr_addr[0], 32'd0);
    chk("w0_data", wr_data[0], 32'h0001_0000);
    wait_writes(2, 40, "second_write");
    chk("w1_addr", wr_addr[1], 32'd1);
    chk("w1_data", wr_data[1], 32'h0003_0002);

    // FLAGA drops between halves of a word
    wait_state(3'd2, 40, "reach_rd_hi");
    FLAGA = 1'b0;
    k = wr_addr.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLKOUT);
      chk("gap_slrd", {31'd0, SLRD}, 32'd1);
      chk("gap_state", {29'd0, cstate}, 32'd2);
    end
    FLAGA = 1'b1;
    wait_writes(k + 1, 40, "gap_write");
    chk("gap_data", wr_data[k], {16'(2 * k + 1), 16'(2 * k)});

    // stall while the slave is already acking
    wait_state(3'd3, 40, "reach_wb");
    while (!sdram_ack && cstate == 3'd3) @(negedge CLKOUT);
    chk("ack_in_wb", {31'd0, sdram_ack}, 32'd1);
    a0 = addr_i;
    d0 = data_i;
    k = wr_addr.size();
    stall_o = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLKOUT);
      chk("stall_stb", {31'd0, stb_i}, 32'd1);
      chk("stall_addr", addr_i, a0);
      chk("stall_data", data_i, d0);
      chk("stall_nowr", wr_addr.size(), k);
    end
    stall_o = 1'b0;
    wait_writes(k + 1, 10, "stall_write");
    chk("stall_waddr", wr_addr[k], a0);
    chk("stall_wdata", wr_data[k], d0);

    // run to completion
    wait_state(3'd5, 2000, "reach_done");
    chk("n_writes", wr_addr.size(), 120);
    chk("read_ack", {31'd0, read_ack}, 32'd1);
    chk("done_led", {28'd0, LED}, 32'hD);
    chk("fifo_pops", {16'd0, fcnt}, 32'd240);
    chk("cyc_gap", b2b, 0);
    for (int i = 0; i < 120; i++) begin
      chk("mem_addr", wr_addr[i], i);
      chk("mem_data", wr_data[i], {16'(2 * i + 1), 16'(2 * i)});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLKOUT);
      chk("done_quiet", {29'd0, SLRD, cyc_i, read_ack}, 32'b101);
    end
    chk("done_nowr", wr_addr.size(), 120);

    // reset out of DONE, then async reset in the middle of a WB cycle
    rst_n = 1'b0;
    @(negedge CLKOUT);
    rst_n = 1'b1;
    wait_state(3'd3, 40, "reach_wb2");
    #2 rst_n = 1'b0;
    #1;
    chk("async_cyc", {31'd0, cyc_i}, 32'd0);
    chk("async_state", {29'd0, cstate}, 32'd0);
    chk("async_addr", addr_i, 32'd0);
    @(negedge CLKOUT);
    rst_n = 1'b1;
    wait_writes(1, 40, "restart_write");
    chk("restart_addr", wr_addr[0], 32'd0);
    chk("restart_data", wr_data[0], 32'h0001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
